mem_arbiter: RTL and testbench

Single-port memory arbiter for the five-stage pipeline CPU. The CPU has two requesters: instruction fetch (PC address) and MEM-stage data access (DMEM_rena/DMEM_wena). Both share one unified single-port RAM with a req/ack handshake and variable latency. The arbiter drives the CPU `stall` input until both accesses for the current CPU step are complete, then releases the pipeline for exactly one cycle.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter_wait_timer.sv | 36 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM encodings,
// default timeout and the saturating counter helper.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_D_ACC = 2'd1;
  localparam logic [1:0] ST_I_ACC = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int ARB_TIMEOUT = 15;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bus between the arbiter and the unified single-port RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Per-access wait counter; flags expiry on the last allowed cycle without an ack.
module arb_wait_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_ack,
  output logic               o_expired,
  output logic [TIMEOUT-1:0] o_count
);

  localparam logic [TIMEOUT-1:0] C_LAST = TIMEOUT'(TIMEOUT - 1);
  localparam logic [TIMEOUT-1:0] C_ONE  = {{(TIMEOUT-1){1'b0}}, 1'b1};

  logic [TIMEOUT-1:0] r_count;

  // wait-cycle counter, restarted at the start of every access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {TIMEOUT{1'b0}};
    end else if (i_clear) begin
      r_count <= {TIMEOUT{1'b0}};
    end else if (!i_ack) begin
      r_count <= r_count + C_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == C_LAST) && !i_ack;
  assign o_count   = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Stalls the CPU while the data access (first) and the instruction fetch are
// serviced over one shared RAM port, then releases the pipeline for one cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_instr,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic              i_d_rena,
  input  logic              i_d_wena,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_cpu_stall,
  mem_arbiter_if.master     mem,
  output logic              o_bus_err,
  output logic [31:0]       o_stall_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_if_addr;
  logic [ADDR_W-1:0] r_d_addr;
  logic [DATA_W-1:0] r_d_wdata;
  logic              r_d_wena;
  logic              r_d_op;
  logic [DATA_W-1:0] r_if_instr;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_bus_err;
  logic [31:0]       r_stall_cnt;

  logic               w_in_acc;
  logic               w_expired;
  logic               w_acc_done;
  logic               w_d_read;
  logic [DATA_W-1:0]  w_cap_data;
  logic [TIMEOUT-1:0] w_wait_cnt;
  logic               w_unused_wait;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;

  assign w_in_acc   = (r_state == ST_D_ACC) || (r_state == ST_I_ACC);
  assign w_acc_done = w_in_acc && (mem.mem_ack || w_expired);
  assign w_d_read   = r_d_op && !r_d_wena;
  // A timed-out access captures zero, which decodes as a NOP on the fetch side.
  assign w_cap_data = mem.mem_ack ? mem.mem_rdata : {DATA_W{1'b0}};

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_in_acc || w_acc_done),
    .i_ack     (mem.mem_ack),
    .o_expired (w_expired),
    .o_count   (w_wait_cnt)
  );

  assign w_unused_wait = ^w_wait_cnt;

  // next-state logic: data access always precedes the fetch
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_d_rena || i_d_wena) begin
          w_next_state = ST_D_ACC;
        end else begin
          w_next_state = ST_I_ACC;
        end
      end
      ST_D_ACC: begin
        if (w_acc_done) begin
          w_next_state = ST_I_ACC;
        end else begin
          w_next_state = ST_D_ACC;
        end
      end
      ST_I_ACC: begin
        if (w_acc_done) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_I_ACC;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // memory address/data mux, driven purely from state and latched requests
  always_comb begin
    w_mem_addr  = {ADDR_W{1'b0}};
    w_mem_wdata = {DATA_W{1'b0}};
    case (r_state)
      ST_D_ACC: begin
        w_mem_addr  = r_d_addr;
        w_mem_wdata = r_d_wdata;
      end
      ST_I_ACC: begin
        w_mem_addr  = r_if_addr;
        w_mem_wdata = {DATA_W{1'b0}};
      end
      default: begin
        w_mem_addr  = {ADDR_W{1'b0}};
        w_mem_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // FSM state, request latches, captured data, error flag and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_if_addr   <= {ADDR_W{1'b0}};
      r_d_addr    <= {ADDR_W{1'b0}};
      r_d_wdata   <= {DATA_W{1'b0}};
      r_d_wena    <= 1'b0;
      r_d_op      <= 1'b0;
      r_if_instr  <= {DATA_W{1'b0}};
      r_d_rdata   <= {DATA_W{1'b0}};
      r_bus_err   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE) begin
        r_if_addr <= i_if_addr;
        r_d_addr  <= i_d_addr;
        r_d_wdata <= i_d_wdata;
        r_d_wena  <= i_d_wena;
        r_d_op    <= i_d_rena || i_d_wena;
      end
      if ((r_state == ST_D_ACC) && w_acc_done && w_d_read) begin
        r_d_rdata <= w_cap_data;
      end
      if ((r_state == ST_I_ACC) && w_acc_done) begin
        r_if_instr <= w_cap_data;
      end
      if (w_in_acc && w_expired) begin
        r_bus_err <= 1'b1;
      end
      if (r_state != ST_DONE) begin
        r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
    end
  end

  assign mem.mem_req   = w_in_acc;
  assign mem.mem_we    = (r_state == ST_D_ACC) && r_d_wena;
  assign mem.mem_addr  = w_mem_addr;
  assign mem.mem_wdata = w_mem_wdata;

  assign o_cpu_stall = (r_state != ST_DONE);
  assign o_if_instr  = r_if_instr;
  assign o_d_rdata   = r_d_rdata;
  assign o_bus_err   = r_bus_err;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a latency-programmable RAM model checks each request against
// queued expectations; each CPU step is checked for latency and captured data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        d_rena, d_wena;
  logic [31:0] if_instr, d_rdata, stall_cnt;
  logic        cpu_stall, bus_err;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_addr   (if_addr),
    .o_if_instr  (if_instr),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .i_d_rena    (d_rena),
    .i_d_wena    (d_wena),
    .o_d_rdata   (d_rdata),
    .o_cpu_stall (cpu_stall),
    .mem         (mem_bus),
    .o_bus_err   (bus_err),
    .o_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_txn_q[$];
  logic [31:0] resp_q[$];
  int          ack_lat = 1;
  logic [31:0] exp_drdata = 32'd0;
  logic        exp_berr = 1'b0;
  int          exp_stall = 0;

  // RAM model: acks the L-th cycle of each access, checks request against the scoreboard
  initial begin : responder
    bit          serving;
    int          cnt;
    int          cur_lat;
    logic [31:0] cur_data;
    txn_t        t;
    serving = 1'b0;
    cnt = 0;
    cur_lat = 0;
    cur_data = 32'd0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'hA5A5_A5A5;
    forever begin
      @(negedge clk);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'hA5A5_A5A5;
      if (serving) begin
        cnt++;
        if (cur_lat != 0 && cnt == cur_lat) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = cur_data;
          serving = 1'b0;
        end else if (!mem_bus.mem_req) begin
          serving = 1'b0;
        end
      end else if (mem_bus.mem_req) begin
        checks++;
        if (exp_txn_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got addr=%h we=%b, none expected", mem_bus.mem_addr, mem_bus.mem_we);
        end else begin
          t = exp_txn_q.pop_front();
          if (mem_bus.mem_we !== t.we || mem_bus.mem_addr !== t.addr ||
              (t.chk_wdata && mem_bus.mem_wdata !== t.wdata)) begin
            errors++;
            $display("FAIL mem_req: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                     mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, t.we, t.addr, t.wdata);
          end
        end
        cur_data = (resp_q.size() != 0) ? resp_q.pop_front() : 32'd0;
        cur_lat  = ack_lat;
        cnt      = 1;
        serving  = 1'b1;
        if (cur_lat == 1) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = cur_data;
          serving = 1'b0;
        end
      end
    end
  end

  // One CPU step, starting at the negedge of an IDLE cycle and ending at the next IDLE.
  task automatic run_step(input string name, input logic [31:0] ifa, input logic [31:0] da,
                          input logic [31:0] dw, input logic rena, input logic wena,
                          input int lat, input logic [31:0] idata, input logic [31:0] ddata);
    txn_t        t;
    int          n;
    int          exp_lat;
    logic        dop;
    logic [31:0] exp_instr;
    dop = rena | wena;
    rst = 1'b0;
    if_addr = ifa; d_addr = da; d_wdata = dw; d_rena = rena; d_wena = wena;
    ack_lat = lat;
    if (dop) begin
      t.we = wena; t.addr = da; t.wdata = dw; t.chk_wdata = 1'b1;
      exp_txn_q.push_back(t);
      resp_q.push_back(ddata);
    end
    t.we = 1'b0; t.addr = ifa; t.wdata = 32'd0; t.chk_wdata = 1'b0;
    exp_txn_q.push_back(t);
    resp_q.push_back(idata);
    if (lat == 0) exp_lat = dop ? 1 + 2 * TIMEOUT : 1 + TIMEOUT;
    else          exp_lat = dop ? 1 + 2 * lat : 1 + lat;
    exp_instr = (lat == 0) ? 32'd0 : idata;
    if (rena && !wena) exp_drdata = (lat == 0) ? 32'd0 : ddata;
    if (lat == 0) exp_berr = 1'b1;
    exp_stall += exp_lat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if_addr = ~ifa; d_addr = ~da; d_wdata = ~dw; d_rena = ~rena; d_wena = 1'b0;
      end
    end while (cpu_stall && n < 200);
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_lat);
    end
    checks++;
    if (if_instr !== exp_instr) begin
      errors++;
      $display("FAIL %s if_instr: got %h, expected %h", name, if_instr, exp_instr);
    end
    checks++;
    if (d_rdata !== exp_drdata) begin
      errors++;
      $display("FAIL %s d_rdata: got %h, expected %h", name, d_rdata, exp_drdata);
    end
    checks++;
    if (bus_err !== exp_berr) begin
      errors++;
      $display("FAIL %s bus_err: got %b, expected %b", name, bus_err, exp_berr);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d, expected %0d", name, stall_cnt, exp_stall);
    end
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s release_one_cycle: got stall=%b req=%b, expected stall=1 req=0",
               name, cpu_stall, mem_bus.mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_addr = 32'h1111_1111; d_addr = 32'h2222_2222; d_wdata = 32'h3333_3333;
    d_rena = 1'b1; d_wena = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1 || mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0 ||
        mem_bus.mem_addr !== 32'd0 || mem_bus.mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem: got stall=%b req=%b we=%b addr=%h wdata=%h, expected 1/0/0/0/0",
               cpu_stall, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    checks++;
    if (if_instr !== 32'd0 || d_rdata !== 32'd0 || bus_err !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: got instr=%h rdata=%h err=%b cnt=%0d, expected all 0",
               if_instr, d_rdata, bus_err, stall_cnt);
    end
  endtask

  task automatic test_fetch_only();
    run_step("fetch_only", 32'h0040_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1, 32'h2008_000A, 32'd0);
  endtask

  task automatic test_load_fetch();
    run_step("load_fetch", 32'h0040_0004, 32'h1001_0004, 32'h0000_0000, 1'b1, 1'b0, 3,
             32'h8C09_0000, 32'h1234_5678);
  endtask

  task automatic test_store();
    run_step("store", 32'h0040_0008, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 1'b1, 2,
             32'h0109_5020, 32'h5555_5555);
  endtask

  task automatic test_rw_both();
    run_step("rw_both", 32'h0040_000C, 32'h1001_000C, 32'hCAFE_0001, 1'b1, 1'b1, 1,
             32'h0000_0020, 32'h7777_7777);
  endtask

  task automatic test_back_to_back();
    run_step("b2b_min", 32'h0040_0010, 32'h1001_0010, 32'd0, 1'b1, 1'b0, 1,
             32'hAC0A_0000, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      run_step("b2b_rand", $urandom, $urandom, $urandom, 1'(i % 2), 1'(i / 2 % 2),
               int'($urandom_range(1, 4)), $urandom, $urandom);
    end
  endtask

  task automatic test_timeout();
    run_step("timeout", 32'h0040_0020, 32'd0, 32'd0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'd0);
    run_step("after_timeout", 32'h0040_0024, 32'h1001_0020, 32'd0, 1'b1, 1'b0, 2,
             32'h2009_0001, 32'h0000_BEEF);
  endtask

  task automatic test_reset_mid();
    txn_t t;
    ack_lat = 3;
    if_addr = 32'h0040_0030; d_addr = 32'h1001_0030; d_wdata = 32'd0;
    d_rena = 1'b1; d_wena = 1'b0;
    t.we = 1'b0; t.addr = 32'h1001_0030; t.wdata = 32'd0; t.chk_wdata = 1'b1;
    exp_txn_q.push_back(t);
    resp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_bus.mem_req !== 1'b0 || cpu_stall !== 1'b1 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got req=%b stall=%b cnt=%0d, expected req=0 stall=1 cnt=0",
               mem_bus.mem_req, cpu_stall, stall_cnt);
    end
    checks++;
    if (bus_err !== 1'b0 || d_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_regs: got err=%b rdata=%h, expected err=0 rdata=0", bus_err, d_rdata);
    end
    exp_stall = 0;
    exp_drdata = 32'd0;
    exp_berr = 1'b0;
    // Late ack is on the bus in this IDLE cycle while reset is released.
    run_step("post_reset", 32'h0040_0034, 32'd0, 32'd0, 1'b0, 1'b0, 2, 32'h0000_0000, 32'd0);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store();
    test_rw_both();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_txn_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending requests, expected 0", exp_txn_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
